// File: rtl/gfx_mem_arbiter_if.sv
// Bus bundle for gfx_mem_arbiter: CPU and renderer request ports, the shared
// memory port, and the LCD timing outputs.
// slave  : the arbiter's view.
// master : the environment's view (requesters and memory).
interface gfx_mem_arbiter_if;
  logic        lcd_en;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ppu_req;
  logic [15:0] ppu_addr;
  logic        ppu_ack;
  logic [7:0]  ppu_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [1:0]  mode;
  logic [7:0]  ly;

  modport slave (
    input  lcd_en, cpu_req, cpu_we, cpu_addr, cpu_wdata, ppu_req, ppu_addr, mem_rdata,
    output cpu_ack, cpu_rdata, ppu_ack, ppu_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           mode, ly
  );

  modport master (
    output lcd_en, cpu_req, cpu_we, cpu_addr, cpu_wdata, ppu_req, ppu_addr, mem_rdata,
    input  cpu_ack, cpu_rdata, ppu_ack, ppu_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           mode, ly
  );
endinterface

// File: rtl/gfx_mem_arbiter.sv
// gfx_mem_arbiter: scanline timing generator plus a two-cycle arbiter that
// shares one synchronous memory port between the CPU and the renderer.
// Optional macro GFX_ACCESS_LOCK_EN enables mode-based CPU lockout
// (OAM in modes 2/3, VRAM in mode 3); without it only the address range
// check sends a CPU access to CPU_LOCK.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting; no grant in the cycle an ack is being returned
// CPU_ACC  | CPU grant cycle, mem_en driven with CPU address/data
// PPU_ACC  | renderer grant cycle, mem_en driven with fetch address
// CPU_LOCK | CPU access refused; no memory strobe, reads return 0xFF
module gfx_mem_arbiter #(
  parameter int LINE_DOTS     = 456,
  parameter int OAM_DOTS      = 80,
  parameter int DRAW_DOTS     = 172,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES   = 154
) (
  input logic clk,
  input logic reset_n,
  gfx_mem_arbiter_if.slave bus
);

  localparam int DOT_W = $clog2(LINE_DOTS);
  localparam logic [DOT_W-1:0] DOT_LAST = DOT_W'(LINE_DOTS - 1);
  localparam logic [DOT_W-1:0] OAM_END  = DOT_W'(OAM_DOTS);
  localparam logic [DOT_W-1:0] DRAW_END = DOT_W'(OAM_DOTS + DRAW_DOTS);
  localparam logic [7:0]       LY_LAST  = 8'(TOTAL_LINES - 1);
  localparam logic [7:0]       LY_VIS   = 8'(VISIBLE_LINES);

  typedef enum logic [1:0] {IDLE, CPU_ACC, PPU_ACC, CPU_LOCK} arbState_t;

  arbState_t        state, nextState;
  logic [DOT_W-1:0] dotCnt;
  logic [7:0]       lineCnt;
  logic [1:0]       modeInt;
  logic             cpuLost, nextLost;
  logic             lockRd;
  logic             isVram, isOam, modeLock, cpuBlocked, holdOff;

  // Dot/line counters; held at the origin while the LCD is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dotCnt  <= '0;
      lineCnt <= '0;
    end else if (!bus.lcd_en) begin
      dotCnt  <= '0;
      lineCnt <= '0;
    end else if (dotCnt == DOT_LAST) begin
      dotCnt  <= '0;
      lineCnt <= (lineCnt == LY_LAST) ? 8'd0 : lineCnt + 8'd1;
    end else begin
      dotCnt <= dotCnt + 1'b1;
    end
  end

  // Mode decode from the registered counters; a disabled LCD reads as HBLANK.
  always_comb begin
    modeInt = 2'd0;
    if (bus.lcd_en) begin
      if (lineCnt >= LY_VIS)      modeInt = 2'd1;
      else if (dotCnt < OAM_END)  modeInt = 2'd2;
      else if (dotCnt < DRAW_END) modeInt = 2'd3;
      else                        modeInt = 2'd0;
    end
  end

  assign bus.mode = modeInt;
  assign bus.ly   = lineCnt;

  assign isVram  = (bus.cpu_addr[15:13] == 3'b100);
  assign isOam   = (bus.cpu_addr[15:8] == 8'hFE) && (bus.cpu_addr[7:0] < 8'hA0);
`ifdef GFX_ACCESS_LOCK_EN
  assign modeLock = (isOam && ((modeInt == 2'd2) || (modeInt == 2'd3))) ||
                    (isVram && (modeInt == 2'd3));
`else
  assign modeLock = 1'b0;
`endif
  assign cpuBlocked = !(isVram || isOam) || modeLock;
  assign holdOff    = bus.cpu_ack || bus.ppu_ack;

  // Next-state: PPU wins ties unless the CPU lost the previous tie.
  always_comb begin
    nextState = state;
    nextLost  = cpuLost;
    case (state)
      IDLE: begin
        if (!holdOff) begin
          if (bus.ppu_req && !(bus.cpu_req && cpuLost)) begin
            nextState = PPU_ACC;
            nextLost  = cpuLost || bus.cpu_req;
          end else if (bus.cpu_req) begin
            nextState = cpuBlocked ? CPU_LOCK : CPU_ACC;
            nextLost  = 1'b0;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State register and registered memory strobe / ack outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cpuLost       <= 1'b0;
      lockRd        <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.ppu_ack   <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state       <= nextState;
      cpuLost     <= nextLost;
      lockRd      <= (state == CPU_LOCK);
      bus.cpu_ack <= (state == CPU_ACC) || (state == CPU_LOCK);
      bus.ppu_ack <= (state == PPU_ACC);
      bus.mem_en  <= (state == IDLE) && ((nextState == CPU_ACC) || (nextState == PPU_ACC));
      bus.mem_we  <= (state == IDLE) && (nextState == CPU_ACC) && bus.cpu_we;
      if ((state == IDLE) && (nextState == CPU_ACC)) begin
        bus.mem_addr  <= bus.cpu_addr;
        bus.mem_wdata <= bus.cpu_wdata;
      end else if ((state == IDLE) && (nextState == PPU_ACC)) begin
        bus.mem_addr <= bus.ppu_addr;
      end
    end
  end

  // Read data arrives one cycle after the strobe, i.e. alongside the ack.
  assign bus.cpu_rdata = bus.cpu_ack ? (lockRd ? 8'hFF : bus.mem_rdata) : 8'h00;
  assign bus.ppu_rdata = bus.ppu_ack ? bus.mem_rdata : 8'h00;

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Directed bench for gfx_mem_arbiter with a behavioural synchronous memory.
module tb_gfx_mem_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

`ifdef GFX_ACCESS_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   gfx_mem_arbiter_if bus();

   gfx_mem_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   logic [7:0] mem [0:65535];

   // Synchronous memory: read data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata <= mem[bus.mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                             output logic [7:0] rd, output int lat,
                             output logic sawEn, output logic sawWe);
      bit got = 0;
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
      lat = 0; sawEn = 1'b0; sawWe = 1'b0; rd = 8'h00;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         if (bus.mem_en) sawEn = 1'b1;
         if (bus.mem_we) sawWe = 1'b1;
         if (bus.cpu_ack) begin rd = bus.cpu_rdata; got = 1; end
      end
      if (!got) lat = 99;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic ppu_access(input logic [15:0] addr, output logic [7:0] rd,
                             output int lat, output logic sawWe);
      bit got = 0;
      bus.ppu_req = 1'b1; bus.ppu_addr = addr;
      lat = 0; sawWe = 1'b0; rd = 8'h00;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         if (bus.mem_we) sawWe = 1'b1;
         if (bus.ppu_ack) begin rd = bus.ppu_rdata; got = 1; end
      end
      if (!got) lat = 99;
      bus.ppu_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic restart_at(input int d);
      bus.lcd_en = 1'b0;
      @(negedge clk);
      bus.lcd_en = 1'b1;
      repeat (d) @(negedge clk);
   endtask

   logic [7:0] rd;
   int         lat;
   logic       en, we;
   int         ord [4];
   int         cyc [4];
   int         n;
   logic [7:0] ppuFirst, cpuFirst;
   logic       sawAck;

   initial begin
      reset_n = 1'b0;
      bus.lcd_en = 1'b1; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0;
      bus.cpu_wdata = 8'h0; bus.ppu_req = 1'b0; bus.ppu_addr = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_cpu_ack", bus.cpu_ack, 1'b0);
      chk("rst_ppu_ack", bus.ppu_ack, 1'b0);
      chk("rst_mem_en", bus.mem_en, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 16'h0000);
      chk("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
      chk("rst_ly", bus.ly, 8'd0);
      reset_n = 1'b1;

      // Scanline timing from dot 0 of line 0.
      chk("mode_dot0", bus.mode, 2'd2);
      repeat (79) @(negedge clk);
      chk("mode_dot79", bus.mode, 2'd2);
      @(negedge clk);
      chk("mode_dot80", bus.mode, 2'd3);
      repeat (171) @(negedge clk);
      chk("mode_dot251", bus.mode, 2'd3);
      @(negedge clk);
      chk("mode_dot252", bus.mode, 2'd0);
      chk("ly_line0", bus.ly, 8'd0);
      repeat (204) @(negedge clk);
      chk("ly_after456", bus.ly, 8'd1);
      chk("mode_line1_dot0", bus.mode, 2'd2);
      repeat (144*456 - 456) @(negedge clk);
      chk("ly_144", bus.ly, 8'd144);
      chk("mode_vblank", bus.mode, 2'd1);
      repeat (10*456 - 1) @(negedge clk);
      chk("ly_153", bus.ly, 8'd153);
      @(negedge clk);
      chk("ly_wrap", bus.ly, 8'd0);
      chk("mode_wrap", bus.mode, 2'd2);

      // LCD disabled: timing frozen at the origin.
      bus.lcd_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("off_mode", bus.mode, 2'd0);
      chk("off_ly", bus.ly, 8'd0);

      // HBLANK CPU write/read and preloads.
      restart_at(260);
      chk("hblank_mode", bus.mode, 2'd0);
      cpu_access(1'b1, 16'h8010, 8'h5A, rd, lat, en, we);
      chk("wr_latency", lat, 2);
      chk("wr_mem_en", en, 1'b1);
      chk("wr_mem_we", we, 1'b1);
      cpu_access(1'b0, 16'h8010, 8'h00, rd, lat, en, we);
      chk("rd_latency", lat, 2);
      chk("rd_data", rd, 8'h5A);
      chk("rd_mem_we", we, 1'b0);
      cpu_access(1'b1, 16'h9000, 8'hA7, rd, lat, en, we);
      cpu_access(1'b1, 16'hFE9F, 8'h3C, rd, lat, en, we);
      cpu_access(1'b1, 16'hFE00, 8'h11, rd, lat, en, we);
      chk("oam_wr_hblank_en", en, 1'b1);

      ppu_access(16'h8010, rd, lat, we);
      chk("ppu_latency", lat, 2);
      chk("ppu_data", rd, 8'h5A);
      chk("ppu_mem_we", we, 1'b0);

      // Both requesters held: grants alternate PPU, CPU, PPU, CPU.
      for (int i = 0; i < 4; i++) begin ord[i] = -1; cyc[i] = -1; end
      n = 0; ppuFirst = 8'h00; cpuFirst = 8'h00;
      bus.cpu_we = 1'b0; bus.cpu_addr = 16'h8010; bus.ppu_addr = 16'h9000;
      bus.cpu_req = 1'b1; bus.ppu_req = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bus.ppu_ack && n < 4) begin
            if (n == 0) ppuFirst = bus.ppu_rdata;
            ord[n] = 1; cyc[n] = c; n++;
         end
         if (bus.cpu_ack && n < 4) begin
            if (n == 1) cpuFirst = bus.cpu_rdata;
            ord[n] = 0; cyc[n] = c; n++;
         end
      end
      bus.cpu_req = 1'b0; bus.ppu_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("alt_count", n, 4);
      chk("alt_0_ppu", ord[0], 1);
      chk("alt_1_cpu", ord[1], 0);
      chk("alt_2_ppu", ord[2], 1);
      chk("alt_3_cpu", ord[3], 0);
      chk("alt_cpu_cycle", cyc[1], 5);
      chk("alt_last_cycle", cyc[3], 11);
      chk("alt_ppu_data", ppuFirst, 8'hA7);
      chk("alt_cpu_data", cpuFirst, 8'h5A);

      // Address range check.
      restart_at(300);
      cpu_access(1'b0, 16'hC000, 8'h00, rd, lat, en, we);
      chk("c000_latency", lat, 2);
      chk("c000_data", rd, 8'hFF);
      chk("c000_mem_en", en, 1'b0);
      cpu_access(1'b0, 16'h7FFF, 8'h00, rd, lat, en, we);
      chk("7fff_data", rd, 8'hFF);
      cpu_access(1'b0, 16'hA000, 8'h00, rd, lat, en, we);
      chk("a000_data", rd, 8'hFF);
      cpu_access(1'b0, 16'hFEA0, 8'h00, rd, lat, en, we);
      chk("fea0_data", rd, 8'hFF);
      chk("fea0_mem_en", en, 1'b0);
      cpu_access(1'b0, 16'hFE9F, 8'h00, rd, lat, en, we);
      chk("fe9f_data", rd, 8'h3C);
      chk("fe9f_mem_en", en, 1'b1);
      cpu_access(1'b1, 16'hC000, 8'h77, rd, lat, en, we);
      chk("c000_wr_latency", lat, 2);
      chk("c000_wr_mem_en", en, 1'b0);

      // Mode-based lockout (only when the lock feature is built in).
      restart_at(10);
      cpu_access(1'b0, 16'hFE00, 8'h00, rd, lat, en, we);
      chk("oam_mode2_data", rd, LOCK ? 8'hFF : 8'h11);
      chk("oam_mode2_mem_en", en, !LOCK);
      cpu_access(1'b0, 16'h8010, 8'h00, rd, lat, en, we);
      chk("vram_mode2_data", rd, 8'h5A);
      restart_at(100);
      chk("draw_mode", bus.mode, 2'd3);
      cpu_access(1'b1, 16'hFE00, 8'h33, rd, lat, en, we);
      chk("oam_mode3_wr_latency", lat, 2);
      chk("oam_mode3_wr_mem_en", en, !LOCK);
      cpu_access(1'b0, 16'h8010, 8'h00, rd, lat, en, we);
      chk("vram_mode3_data", rd, LOCK ? 8'hFF : 8'h5A);
      ppu_access(16'h9000, rd, lat, we);
      chk("ppu_mode3_latency", lat, 2);
      chk("ppu_mode3_data", rd, 8'hA7);
      restart_at(300);
      cpu_access(1'b0, 16'hFE00, 8'h00, rd, lat, en, we);
      chk("oam_hblank_readback", rd, LOCK ? 8'h11 : 8'h33);

      // LCD off: no lockout at all.
      bus.lcd_en = 1'b0;
      repeat (2) @(negedge clk);
      cpu_access(1'b0, 16'hFE00, 8'h00, rd, lat, en, we);
      chk("lcdoff_oam_data", rd, LOCK ? 8'h11 : 8'h33);

      // Reset in the grant cycle abandons the transaction.
      bus.lcd_en = 1'b1;
      bus.cpu_we = 1'b0; bus.cpu_addr = 16'h8010; bus.cpu_req = 1'b1;
      @(negedge clk);
      chk("mid_grant_mem_en", bus.mem_en, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_mem_en", bus.mem_en, 1'b0);
      chk("mid_rst_mem_we", bus.mem_we, 1'b0);
      chk("mid_rst_mem_addr", bus.mem_addr, 16'h0000);
      chk("mid_rst_mem_wdata", bus.mem_wdata, 8'h00);
      chk("mid_rst_cpu_ack", bus.cpu_ack, 1'b0);
      chk("mid_rst_ppu_ack", bus.ppu_ack, 1'b0);
      chk("mid_rst_cpu_rdata", bus.cpu_rdata, 8'h00);
      chk("mid_rst_ppu_rdata", bus.ppu_rdata, 8'h00);
      chk("mid_rst_ly", bus.ly, 8'd0);
      sawAck = 1'b0;
      repeat (2) begin @(negedge clk); if (bus.cpu_ack) sawAck = 1'b1; end
      bus.cpu_req = 1'b0;
      reset_n = 1'b1;
      repeat (3) begin @(negedge clk); if (bus.cpu_ack) sawAck = 1'b1; end
      chk("mid_rst_no_ack", sawAck, 1'b0);
      bus.lcd_en = 1'b0;
      @(negedge clk);
      cpu_access(1'b0, 16'h8010, 8'h00, rd, lat, en, we);
      chk("post_rst_latency", lat, 2);
      chk("post_rst_data", rd, 8'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
